// File: rtl/fxyz_sweep_check_if.sv
`default_nettype none
// ============================================================================
//  Module      : fxyz_sweep_check_if
//  Description : Control, status and function-block signals of the fxyz
//                sweep checker, bundled as one interface. The master side
//                is the checker and the slave side is its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fxyz_sweep_check_if #(
   parameter int N = 3
);
   logic         start;
   logic         abort;
   logic         s1;
   logic         s2;
   logic [N-1:0] vec;
   logic         busy;
   logic         done;
   logic         pass;
   logic         mismatch;
   logic [N:0]   err_count;
   logic [N-1:0] first_err;
   logic         first_err_valid;

   modport master (
      input  start,
      input  abort,
      input  s1,
      input  s2,
      output vec,
      output busy,
      output done,
      output pass,
      output mismatch,
      output err_count,
      output first_err,
      output first_err_valid
   );

   modport slave (
      output start,
      output abort,
      output s1,
      output s2,
      input  vec,
      input  busy,
      input  done,
      input  pass,
      input  mismatch,
      input  err_count,
      input  first_err,
      input  first_err_valid
   );
endinterface
`default_nettype wire

// File: rtl/fxyz_sweep_check.sv
`default_nettype none
// ============================================================================
//  Module      : fxyz_sweep_check
//  Description : Exhaustive-sweep stimulus generator and equivalence checker
//                for the fxyz boolean stage. Walks vec through 0..2^N-1,
//                holding each value SETTLE+1 cycles, samples s1 against s2
//                on the last cycle of each window, and reports pass/fail,
//                the mismatch count and the first failing vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module fxyz_sweep_check #(
   parameter int N      = 3,
   parameter int SETTLE = 1
) (
   input  logic               clk,
   input  logic               reset,
   fxyz_sweep_check_if.master bus
);

   localparam logic [1:0]   c_st_idle  = 2'd0;
   localparam logic [1:0]   c_st_run   = 2'd1;
   localparam logic [1:0]   c_st_done  = 2'd2;

   // Hold counter is 8 bits wide because SETTLE is limited to 0..255.
   localparam logic [7:0]   c_settle   = 8'(SETTLE);
   localparam logic [N-1:0] c_vec_last = {N{1'b1}};
   localparam logic [N-1:0] c_vec_one  = N'(1);
   localparam logic [N:0]   c_err_one  = (N+1)'(1);

   logic [1:0]   r_state;
   logic [1:0]   w_state_next;

   logic [7:0]   r_cnt;
   logic [7:0]   w_cnt_next;
   logic [N-1:0] r_vec;
   logic [N-1:0] w_vec_next;
   logic         r_busy;
   logic         w_busy_next;
   logic         r_done;
   logic         w_done_next;
   logic         r_pass;
   logic         w_pass_next;
   logic         r_mismatch;
   logic         w_mismatch_next;
   logic [N:0]   r_err_count;
   logic [N:0]   w_err_count_next;
   logic [N-1:0] r_first_err;
   logic [N-1:0] w_first_err_next;
   logic         r_first_err_valid;
   logic         w_first_err_valid_next;

   logic         w_window_end;
   logic         w_last_vec;
   logic         w_diff;

   // Last cycle of the current vector's hold window.
   assign w_window_end = (r_cnt == 8'd0);
   assign w_last_vec   = (r_vec == c_vec_last);
   assign w_diff       = bus.s1 ^ bus.s2;

   // State register; reset is asynchronous so a sweep stops without a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode: abort beats the final sample, start only from IDLE/DONE.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle, c_st_done: begin
            if (bus.start) begin
               w_state_next = c_st_run;
            end
         end
         c_st_run: begin
            if (bus.abort) begin
               w_state_next = c_st_idle;
            end else if (w_window_end && w_last_vec) begin
               w_state_next = c_st_done;
            end
         end
         default: begin
            w_state_next = c_st_idle;
         end
      endcase
   end

   // Next values of the registered outputs and the hold counter.
   always_comb begin
      w_cnt_next             = r_cnt;
      w_vec_next             = r_vec;
      w_busy_next            = r_busy;
      w_done_next            = r_done;
      w_pass_next            = r_pass;
      w_mismatch_next        = 1'b0;
      w_err_count_next       = r_err_count;
      w_first_err_next       = r_first_err;
      w_first_err_valid_next = r_first_err_valid;

      case (r_state)
         c_st_idle, c_st_done: begin
            // A new sweep clears every result, including a stale pass flag,
            // so pass reads 0 for the whole of RUN.
            if (bus.start) begin
               w_vec_next             = '0;
               w_cnt_next             = c_settle;
               w_busy_next            = 1'b1;
               w_done_next            = 1'b0;
               w_pass_next            = 1'b0;
               w_err_count_next       = '0;
               w_first_err_next       = '0;
               w_first_err_valid_next = 1'b0;
            end
         end

         c_st_run: begin
            if (bus.abort) begin
               // Partial err_count/first_err are kept for inspection.
               w_busy_next = 1'b0;
               w_vec_next  = '0;
               w_cnt_next  = 8'd0;
            end else if (!w_window_end) begin
               w_cnt_next = r_cnt - 8'd1;
            end else begin
               w_mismatch_next = w_diff;
               if (w_diff) begin
                  // Width N+1 holds 2^N, so this cannot wrap.
                  w_err_count_next = r_err_count + c_err_one;
                  if (!r_first_err_valid) begin
                     w_first_err_next       = r_vec;
                     w_first_err_valid_next = 1'b1;
                  end
               end
               if (w_last_vec) begin
                  // vec stays parked on the last vector.
                  w_busy_next = 1'b0;
                  w_done_next = 1'b1;
                  w_pass_next = !w_diff && (r_err_count == '0);
               end else begin
                  w_vec_next = r_vec + c_vec_one;
                  w_cnt_next = c_settle;
               end
            end
         end

         default: begin
            w_busy_next = 1'b0;
            w_vec_next  = '0;
            w_cnt_next  = 8'd0;
         end
      endcase
   end

   // Output and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt             <= 8'd0;
         r_vec             <= '0;
         r_busy            <= 1'b0;
         r_done            <= 1'b0;
         r_pass            <= 1'b0;
         r_mismatch        <= 1'b0;
         r_err_count       <= '0;
         r_first_err       <= '0;
         r_first_err_valid <= 1'b0;
      end else begin
         r_cnt             <= w_cnt_next;
         r_vec             <= w_vec_next;
         r_busy            <= w_busy_next;
         r_done            <= w_done_next;
         r_pass            <= w_pass_next;
         r_mismatch        <= w_mismatch_next;
         r_err_count       <= w_err_count_next;
         r_first_err       <= w_first_err_next;
         r_first_err_valid <= w_first_err_valid_next;
      end
   end

   assign bus.vec             = r_vec;
   assign bus.busy            = r_busy;
   assign bus.done            = r_done;
   assign bus.pass            = r_pass;
   assign bus.mismatch        = r_mismatch;
   assign bus.err_count       = r_err_count;
   assign bus.first_err       = r_first_err;
   assign bus.first_err_valid = r_first_err_valid;

endmodule
`default_nettype wire

// File: tb/tb_fxyz_sweep_check.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fxyz_sweep_check
//  Description : Scoreboard bench for fxyz_sweep_check. Two instances
//                (SETTLE=1 and SETTLE=0) are driven by an fxyz model whose
//                s2 leg can be replaced by faulty versions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fxyz_sweep_check;

   localparam int N    = 3;
   localparam int NVEC = 1 << N;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   always #5 clk = ~clk;

   // Number of rising edges so far; read on falling edges.
   always @(posedge clk) cyc <= cyc + 1;

   fxyz_sweep_check_if #(.N(N)) bus0 ();
   fxyz_sweep_check_if #(.N(N)) bus1 ();

   fxyz_sweep_check #(.N(N), .SETTLE(1)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   fxyz_sweep_check #(.N(N), .SETTLE(0)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   // s2 source per instance: 0 real simplified, 1 tied 0, 2 ~s1, 3 random flips.
   int         mode0 = 0;
   int         mode1 = 0;
   logic [7:0] mask0 = '0;
   logic [7:0] mask1 = '0;

   function automatic logic f_unsimp(logic [2:0] v);
      logic x, y, z;
      x = v[2]; y = v[1]; z = v[0];
      return (~x & ~y & z) | (~x & y & z) | (x & y & z);
   endfunction

   function automatic logic f_simp(logic [2:0] v);
      return v[0] & (~v[2] | v[1]);
   endfunction

   function automatic logic drive_s2(int m, logic [7:0] mk, logic [2:0] v);
      case (m)
         0:       return f_simp(v);
         1:       return 1'b0;
         2:       return ~f_unsimp(v);
         default: return f_simp(v) ^ mk[v];
      endcase
   endfunction

   assign bus0.s1 = f_unsimp(bus0.vec);
   assign bus0.s2 = drive_s2(mode0, mask0, bus0.vec);
   assign bus1.s1 = f_unsimp(bus1.vec);
   assign bus1.s2 = drive_s2(mode1, mask1, bus1.vec);

   // Reference: the boolean function is true exactly for vectors 1, 3 and 7.
   function automatic bit ref_fails(int m, logic [7:0] mk, int k);
      bit a, b;
      a = (k == 1) || (k == 3) || (k == 7);
      case (m)
         0:       b = a;
         1:       b = 1'b0;
         2:       b = !a;
         default: b = a ^ mk[k];
      endcase
      return a != b;
   endfunction

   typedef struct { int inst; int cyc; int cnt; } mis_t;
   typedef struct { int inst; int cyc; int cnt; int first; bit fev; bit pass; } done_t;

   mis_t  mq[$];
   done_t dq[$];
   int    s0[2];
   int    settle[2] = '{1, 0};
   logic  done_q[2] = '{1'b0, 1'b0};

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic note_missing(string name, int due);
      n_cmp++;
      n_err++;
      $display("FAIL %s: actual=absent required=event at cycle %0d (now %0d)", name, due, cyc);
   endtask

   task automatic purge(int i, int from_cyc);
      int j;
      j = 0;
      while (j < mq.size()) begin
         if (mq[j].inst == i && mq[j].cyc >= from_cyc) mq.delete(j);
         else j++;
      end
      j = 0;
      while (j < dq.size()) begin
         if (dq[j].inst == i) dq.delete(j);
         else j++;
      end
   endtask

   function automatic bit pending(int i);
      foreach (dq[j]) if (dq[j].inst == i) return 1'b1;
      return 1'b0;
   endfunction

   task automatic monitor(int i, logic [N-1:0] vec, logic busy, logic done, logic pass,
                          logic mis, logic [N:0] ec, logic [N-1:0] fe, logic fev);
      int idx;
      int j;
      if (busy === 1'b1)
         chk($sformatf("vec_step[%0d]", i), vec, (cyc - s0[i]) / (settle[i] + 1));
      if (mis === 1'b1) begin
         idx = -1;
         foreach (mq[k]) if (idx < 0 && mq[k].inst == i) idx = k;
         if (idx < 0) begin
            chk($sformatf("unexpected_mismatch[%0d]", i), mis, 0);
         end else begin
            chk($sformatf("mismatch_cycle[%0d]", i), cyc, mq[idx].cyc);
            chk($sformatf("mismatch_count[%0d]", i), ec, mq[idx].cnt);
            mq.delete(idx);
         end
      end
      if (done === 1'b1 && done_q[i] !== 1'b1) begin
         idx = -1;
         foreach (dq[k]) if (idx < 0 && dq[k].inst == i) idx = k;
         if (idx < 0) begin
            chk($sformatf("unexpected_done[%0d]", i), done, 0);
         end else begin
            chk($sformatf("done_cycle[%0d]", i), cyc, dq[idx].cyc);
            chk($sformatf("err_count[%0d]", i), ec, dq[idx].cnt);
            chk($sformatf("first_err[%0d]", i), fe, dq[idx].first);
            chk($sformatf("first_err_valid[%0d]", i), fev, dq[idx].fev);
            chk($sformatf("pass[%0d]", i), pass, dq[idx].pass);
            chk($sformatf("busy_at_done[%0d]", i), busy, 0);
            dq.delete(idx);
         end
      end
      done_q[i] = done;
      // Any expected event whose cycle has gone by was never presented.
      j = 0;
      while (j < mq.size()) begin
         if (mq[j].inst == i && mq[j].cyc < cyc) begin
            note_missing($sformatf("mismatch_pulse[%0d]", i), mq[j].cyc);
            mq.delete(j);
         end else j++;
      end
      j = 0;
      while (j < dq.size()) begin
         if (dq[j].inst == i && dq[j].cyc < cyc) begin
            note_missing($sformatf("done_rise[%0d]", i), dq[j].cyc);
            dq.delete(j);
         end else j++;
      end
   endtask

   always @(negedge clk) begin
      monitor(0, bus0.vec, bus0.busy, bus0.done, bus0.pass, bus0.mismatch,
              bus0.err_count, bus0.first_err, bus0.first_err_valid);
      monitor(1, bus1.vec, bus1.busy, bus1.done, bus1.pass, bus1.mismatch,
              bus1.err_count, bus1.first_err, bus1.first_err_valid);
   end

   // Issue start for one sweep and push the expected responses.
   task automatic start_sweep(int i, int m, logic [7:0] mk);
      int c0, cnt, first;
      @(negedge clk);
      if (i == 0) begin mode0 = m; mask0 = mk; bus0.start = 1'b1; end
      else        begin mode1 = m; mask1 = mk; bus1.start = 1'b1; end
      c0    = cyc + 1;
      s0[i] = c0;
      cnt   = 0;
      first = -1;
      for (int k = 0; k < NVEC; k++) begin
         if (ref_fails(m, mk, k)) begin
            cnt++;
            if (first < 0) first = k;
            mq.push_back('{i, c0 + (k + 1) * (settle[i] + 1), cnt});
         end
      end
      dq.push_back('{i, c0 + NVEC * (settle[i] + 1), cnt,
                     (first < 0) ? 0 : first, first >= 0, cnt == 0});
      @(negedge clk);
      if (i == 0) bus0.start = 1'b0;
      else        bus1.start = 1'b0;
   endtask

   task automatic wait_done(int i);
      int budget;
      budget = 300;
      while (pending(i) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         note_missing($sformatf("sweep_timeout[%0d]", i), cyc);
         purge(i, 0);
      end
      @(negedge clk);
   endtask

   task automatic check_all_zero(string tag, int i);
      if (i == 0) begin
         chk({tag, ".vec"}, bus0.vec, 0);        chk({tag, ".busy"}, bus0.busy, 0);
         chk({tag, ".done"}, bus0.done, 0);      chk({tag, ".pass"}, bus0.pass, 0);
         chk({tag, ".mismatch"}, bus0.mismatch, 0);
         chk({tag, ".err_count"}, bus0.err_count, 0);
         chk({tag, ".first_err"}, bus0.first_err, 0);
         chk({tag, ".first_err_valid"}, bus0.first_err_valid, 0);
      end else begin
         chk({tag, ".vec"}, bus1.vec, 0);        chk({tag, ".busy"}, bus1.busy, 0);
         chk({tag, ".done"}, bus1.done, 0);      chk({tag, ".pass"}, bus1.pass, 0);
         chk({tag, ".mismatch"}, bus1.mismatch, 0);
         chk({tag, ".err_count"}, bus1.err_count, 0);
         chk({tag, ".first_err"}, bus1.first_err, 0);
         chk({tag, ".first_err_valid"}, bus1.first_err_valid, 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      bus0.start = 1'b0; bus0.abort = 1'b0;
      bus1.start = 1'b0; bus1.abort = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset0", 0);
      check_all_zero("reset1", 1);
      reset = 1'b0;

      // Real fxyz on both legs: clean sweep.
      start_sweep(0, 0, 8'h00);
      wait_done(0);

      // Abort has no effect in DONE.
      bus0.abort = 1'b1; @(negedge clk); bus0.abort = 1'b0; @(negedge clk);
      chk("abort_in_done.done", bus0.done, 1);
      chk("abort_in_done.pass", bus0.pass, 1);

      // s2 tied low: failures at 1, 3, 7.
      start_sweep(0, 1, 8'h00);
      wait_done(0);

      // Restart from DONE after a failing sweep clears the results at that edge.
      start_sweep(0, 0, 8'h00);
      chk("restart.done", bus0.done, 0);
      chk("restart.err_count", bus0.err_count, 0);
      chk("restart.first_err_valid", bus0.first_err_valid, 0);
      chk("restart.vec", bus0.vec, 0);
      chk("restart.busy", bus0.busy, 1);
      wait_done(0);

      // SETTLE=0, every vector fails.
      start_sweep(1, 2, 8'h00);
      wait_done(1);

      // Abort at edge 5 of a SETTLE=1 sweep (vectors 0 and 1 already sampled).
      start_sweep(0, 2, 8'h00);
      while (cyc != s0[0] + 4) @(negedge clk);
      bus0.abort = 1'b1;
      @(negedge clk);
      bus0.abort = 1'b0;
      purge(0, s0[0] + 5);
      chk("abort.busy", bus0.busy, 0);
      chk("abort.vec", bus0.vec, 0);
      chk("abort.done", bus0.done, 0);
      chk("abort.pass", bus0.pass, 0);
      chk("abort.mismatch", bus0.mismatch, 0);
      chk("abort.err_count", bus0.err_count, 2);
      chk("abort.first_err_valid", bus0.first_err_valid, 1);
      repeat (3) @(negedge clk);
      chk("abort.stays_idle", bus0.busy, 0);

      // Abort in IDLE keeps the partial results.
      bus0.abort = 1'b1; @(negedge clk); bus0.abort = 1'b0; @(negedge clk);
      chk("abort_in_idle.err_count", bus0.err_count, 2);
      chk("abort_in_idle.busy", bus0.busy, 0);

      start_sweep(0, 3, 8'($urandom));
      wait_done(0);

      // A second start at edge 3 is ignored.
      start_sweep(0, 3, 8'($urandom));
      while (cyc != s0[0] + 2) @(negedge clk);
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      wait_done(0);

      // Reset between edges 7 and 8 clears everything without a clock.
      start_sweep(0, 2, 8'h00);
      while (cyc != s0[0] + 7) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("async_reset0", 0);
      check_all_zero("async_reset1", 1);
      purge(0, 0);
      purge(1, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      start_sweep(0, 0, 8'h00);
      wait_done(0);

      // Random sweeps on either instance.
      for (int r = 0; r < 10; r++) begin
         int inst;
         inst = int'($urandom_range(0, 1));
         start_sweep(inst, int'($urandom_range(0, 3)), 8'($urandom));
         wait_done(inst);
      end

      chk("scoreboard_drained", mq.size() + dq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
